pwl_func_multi: RTL and testbench



---
 rtl/pwl_func_multi.sv | 138 +++++++++++++
 tb/tb_pwl_func_multi.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwl_func_multi.sv
// Multi-channel piecewise-linear function evaluator with double-buffered
// coefficient tables, atomic bank commit and a 3-stage saturating pipeline.
module pwl_func_multi #(
  parameter int unsigned n_ch      = 2,
  parameter int unsigned in_bits   = 16,
  parameter int unsigned addr_bits = 9,
  parameter int unsigned data_bits = 18,
  parameter int unsigned out_bits  = 18
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  input  logic [n_ch*in_bits-1:0]                     in_,
  output logic                                        out_valid,
  output logic [n_ch*out_bits-1:0]                    out,
  input  logic [data_bits-1:0]                        wdata0,
  input  logic [data_bits-1:0]                        wdata1,
  input  logic [addr_bits-1:0]                        waddr,
  input  logic [((n_ch > 1) ? $clog2(n_ch) : 1)-1:0] wch,
  input  logic                                        we,
  input  logic                                        commit,
  output logic                                        commit_ack,
  output logic                                        active_bank
);

  localparam int unsigned WCH_BITS  = (n_ch > 1) ? $clog2(n_ch) : 1;
  localparam int unsigned FRAC_BITS = in_bits - addr_bits;
  localparam int unsigned DEPTH     = 2 ** addr_bits;
  localparam int unsigned ENTRY     = 2 * data_bits;
  localparam int unsigned PROD_BITS = data_bits + FRAC_BITS + 1;
  localparam int unsigned SUM_BITS  = ((PROD_BITS > out_bits) ? PROD_BITS : out_bits) + 1;

  // Per channel, per bank: {offset, slope}
  logic [ENTRY-1:0]     mem [n_ch][2][DEPTH];

  logic                 wbank;
  logic [addr_bits-1:0] idx_c  [n_ch];
  logic [FRAC_BITS-1:0] frac_c [n_ch];
  logic [addr_bits-1:0] idx1   [n_ch];
  logic [FRAC_BITS-1:0] frac1  [n_ch];
  logic [FRAC_BITS-1:0] frac2  [n_ch];
  logic [ENTRY-1:0]     rd     [n_ch];
  logic [out_bits-1:0]  y_c    [n_ch];
  logic                 bank1;
  logic                 v1;
  logic                 v2;
  logic signed [SUM_BITS-1:0] sat_hi;
  logic signed [SUM_BITS-1:0] sat_lo;

  assign wbank  = ~active_bank;
  assign sat_hi = {{(SUM_BITS-out_bits+1){1'b0}}, {(out_bits-1){1'b1}}};
  assign sat_lo = {{(SUM_BITS-out_bits+1){1'b1}}, {(out_bits-1){1'b0}}};

  // Per-channel index split and S3 arithmetic
  for (genvar c = 0; c < n_ch; c++) begin : g_ch
    logic [in_bits-1:0]          x;
    logic [in_bits-1:0]          u;
    logic signed [data_bits-1:0] off;
    logic signed [data_bits-1:0] slp;
    logic signed [PROD_BITS-1:0] prod;
    logic signed [SUM_BITS-1:0]  sum;

    // Offset-binary conversion is an MSB flip
    assign x         = in_[c*in_bits +: in_bits];
    assign u         = {~x[in_bits-1], x[in_bits-2:0]};
    assign idx_c[c]  = u[in_bits-1 -: addr_bits];
    assign frac_c[c] = u[FRAC_BITS-1:0];

    assign off  = $signed(rd[c][ENTRY-1 -: data_bits]);
    assign slp  = $signed(rd[c][data_bits-1:0]);
    assign prod = PROD_BITS'(slp) * PROD_BITS'($signed({1'b0, frac2[c]}));
    assign sum  = SUM_BITS'(off) + SUM_BITS'(prod >>> FRAC_BITS);
    assign y_c[c] = (sum > sat_hi) ? out_bits'(sat_hi) :
                    (sum < sat_lo) ? out_bits'(sat_lo) : out_bits'(sum);
  end

  // Bank select and commit handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      active_bank <= 1'b0;
      commit_ack  <= 1'b0;
    end else begin
      if (commit) active_bank <= ~active_bank;
      commit_ack <= commit;
    end
  end

  // Table writes always target the shadow bank; out-of-range channels match nothing
  always_ff @(posedge clk) begin
    for (int c = 0; c < n_ch; c++) begin
      if (we && (wch == WCH_BITS'(c))) mem[c][wbank][waddr] <= {wdata0, wdata1};
    end
  end

  // Valid pipeline; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  // S1: capture index, fraction and the bank this sample will use
  always_ff @(posedge clk) begin
    if (in_valid) begin
      bank1 <= active_bank;
      for (int c = 0; c < n_ch; c++) begin
        idx1[c]  <= idx_c[c];
        frac1[c] <= frac_c[c];
      end
    end
  end

  // S2: synchronous table read from the captured bank
  always_ff @(posedge clk) begin
    if (v1) begin
      for (int c = 0; c < n_ch; c++) begin
        rd[c]    <= mem[c][bank1][idx1[c]];
        frac2[c] <= frac1[c];
      end
    end
  end

  // S3: register saturated result; hold while idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      out <= '0;
    end else if (v2) begin
      for (int c = 0; c < n_ch; c++) out[c*out_bits +: out_bits] <= y_c[c];
    end
  end

endmodule

// File: tb/tb_pwl_func_multi.sv
// Bench for pwl_func_multi: vector table + scoreboard queue, plus commit/reset sequences.
module tb_pwl_func_multi;
  localparam int unsigned NCH = 3;
  localparam int unsigned IB  = 16;
  localparam int unsigned AB  = 9;
  localparam int unsigned DB  = 18;
  localparam int unsigned OB  = 18;
  localparam int unsigned WB  = 2;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [NCH*IB-1:0] in_;
  logic              out_valid;
  logic [NCH*OB-1:0] out;
  logic [DB-1:0]     wdata0;
  logic [DB-1:0]     wdata1;
  logic [AB-1:0]     waddr;
  logic [WB-1:0]     wch;
  logic              we;
  logic              commit;
  logic              commit_ack;
  logic              active_bank;

  pwl_func_multi #(
    .n_ch(NCH), .in_bits(IB), .addr_bits(AB), .data_bits(DB), .out_bits(OB)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_(in_),
    .out_valid(out_valid), .out(out),
    .wdata0(wdata0), .wdata1(wdata1), .waddr(waddr), .wch(wch),
    .we(we), .commit(commit), .commit_ack(commit_ack), .active_bank(active_bank)
  );

  typedef struct {
    int x0;
    int x1;
    int e0;
    int e1;
  } vec_t;

  typedef struct {
    int             e[NCH];
    logic [NCH-1:0] m;
  } exp_t;

  vec_t vecs[9];
  exp_t sbq[$];
  exp_t ex;
  int   total  = 0;
  int   passed = 0;
  logic exp_bank;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // Scoreboard: every out_valid must match the oldest pending sample
  always @(negedge clk) begin
    if (out_valid) begin
      check("sb_pending", longint'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        ex = sbq.pop_front();
        for (int c = 0; c < NCH; c++)
          if (ex.m[c]) check($sformatf("out_ch%0d", c), longint'($signed(out[c*OB +: OB])), ex.e[c]);
      end
    end
  end

  task automatic issue(input int x0, input int x1, input int x2,
                       input int e0, input int e1, input int e2,
                       input logic [NCH-1:0] m, input bit push);
    exp_t t;
    in_valid = 1'b1;
    in_      = {IB'(x2), IB'(x1), IB'(x0)};
    t.e[0] = e0; t.e[1] = e1; t.e[2] = e2; t.m = m;
    if (push) sbq.push_back(t);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wr(input int ch, input int a, input int o, input int s);
    we = 1'b1; wch = WB'(ch); waddr = AB'(a); wdata0 = DB'(o); wdata1 = DB'(s);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit   = 1'b0;
    exp_bank = ~exp_bank;
    check("commit_ack", longint'(commit_ack), 1);
    check("active_bank", longint'(active_bank), longint'(exp_bank));
    @(negedge clk);
    check("commit_ack_clr", longint'(commit_ack), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    check("drained", longint'(sbq.size()), 0);
  endtask

  initial begin
    // Bank 1 after first commit: ch0@256 {1000,128}, ch1@256 {131000,131071}
    vecs[0] = '{x0: 0,      x1: 127, e0: 1000, e1: 131071};
    vecs[1] = '{x0: 64,     x1: 0,   e0: 1064, e1: 131000};
    vecs[2] = '{x0: 127,    x1: 1,   e0: 1127, e1: 131071};
    // Bank 0 after second commit: ch0@256 {5,0}, @257 {-100,-3}, @0 {-7,50},
    // @511 {200,-128}; ch1@256 {-131072,-131072}
    vecs[3] = '{x0: 0,      x1: 127, e0: 5,    e1: -131072};
    vecs[4] = '{x0: 129,    x1: 0,   e0: -101, e1: -131072};
    vecs[5] = '{x0: 128,    x1: 0,   e0: -100, e1: -131072};
    vecs[6] = '{x0: 255,    x1: 0,   e0: -103, e1: -131072};
    vecs[7] = '{x0: -32768, x1: 0,   e0: -7,   e1: -131072};
    vecs[8] = '{x0: 32767,  x1: 0,   e0: 73,   e1: -131072};

    rst = 1'b0; in_valid = 1'b1; in_ = '0; we = 1'b0; commit = 1'b0;
    wch = '0; waddr = '0; wdata0 = '0; wdata1 = '0; exp_bank = 1'b0;

    // Reset held with in_valid asserted
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out", longint'(out), 0);
      check("rst_active_bank", longint'(active_bank), 0);
      check("rst_commit_ack", longint'(commit_ack), 0);
    end

    // First sample after release appears after exactly three edges
    rst = 1'b1;
    issue(0, 0, 0, 0, 0, 0, 3'b000, 1'b1);
    check("lat_edge1", longint'(out_valid), 0);
    @(negedge clk);
    check("lat_edge2", longint'(out_valid), 0);
    @(negedge clk);
    check("lat_edge3", longint'(out_valid), 1);
    drain();

    // Basic evaluation and positive saturation
    wr(0, 256, 1000, 128);
    wr(1, 256, 131000, 131071);
    do_commit();
    for (int i = 0; i < 3; i++)
      issue(vecs[i].x0, vecs[i].x1, 0, vecs[i].e0, vecs[i].e1, 0, 3'b011, 1'b1);
    drain();

    // Negative saturation, floor of negative slope, range edges
    wr(1, 256, -131072, -131072);
    wr(0, 256, 5, 0);
    wr(0, 257, -100, -3);
    wr(0, 0, -7, 50);
    wr(0, 511, 200, -128);
    do_commit();
    for (int i = 3; i < 9; i++)
      issue(vecs[i].x0, vecs[i].x1, 0, vecs[i].e0, vecs[i].e1, 0, 3'b011, 1'b1);
    drain();

    // Commit mid-stream: samples up to the commit edge use bank 0 (5), later bank 1 (9)
    wr(0, 256, 9, 0);
    for (int i = 0; i < 6; i++) begin
      commit = (i == 2);
      issue(0, 0, 0, (i <= 2) ? 5 : 9, 0, 0, 3'b001, 1'b1);
      commit = 1'b0;
      if (i == 2) begin
        exp_bank = ~exp_bank;
        check("stream_commit_ack", longint'(commit_ack), 1);
        check("stream_active_bank", longint'(active_bank), longint'(exp_bank));
      end
      if (i == 3) check("stream_ack_clr", longint'(commit_ack), 0);
      if (i >= 2) check("stream_no_gap", longint'(out_valid), 1);
    end
    drain();

    // Write and commit together: entry lands in the bank that becomes active
    we = 1'b1; wch = 2'd0; waddr = 9'd256; wdata0 = 18'd77; wdata1 = '0; commit = 1'b1;
    @(negedge clk);
    we = 1'b0; commit = 1'b0; exp_bank = ~exp_bank;
    check("wc_commit_ack", longint'(commit_ack), 1);
    check("wc_active_bank", longint'(active_bank), longint'(exp_bank));
    issue(0, 0, 0, 77, 0, 0, 3'b001, 1'b1);
    drain();

    // Write to channel index n_ch must not disturb any table
    wr(2, 256, -500, 0);
    wr(3, 256, 1234, 0);
    do_commit();
    issue(0, 0, 0, 9, 131000, -500, 3'b111, 1'b1);
    drain();

    // Back-to-back commits toggle every cycle
    commit = 1'b1;
    @(negedge clk);
    exp_bank = ~exp_bank;
    check("b2b_bank_a", longint'(active_bank), longint'(exp_bank));
    check("b2b_ack_a", longint'(commit_ack), 1);
    @(negedge clk);
    exp_bank = ~exp_bank;
    check("b2b_bank_b", longint'(active_bank), longint'(exp_bank));
    check("b2b_ack_b", longint'(commit_ack), 1);
    commit = 1'b0;
    @(negedge clk);
    check("b2b_ack_clr", longint'(commit_ack), 0);

    // Reset with two samples in flight: both discarded, bank returns to 0
    issue(0, 0, 0, 0, 0, 0, 3'b000, 1'b0);
    issue(0, 0, 0, 0, 0, 0, 3'b000, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; exp_bank = 1'b0;
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_active_bank", longint'(active_bank), 0);
    check("mid_rst_out", longint'(out), 0);
    repeat (4) begin
      @(negedge clk);
      check("mid_rst_quiet", longint'(out_valid), 0);
    end

    // Bank 0 contents survived reset
    issue(0, 127, 0, 77, -131072, 0, 3'b011, 1'b1);
    issue(129, 0, 0, -101, -131072, 0, 3'b011, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
